// File: rtl/mips_store_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_store_checker_if
// Description : Data-memory write port of the single-cycle MIPS core, as seen
//               by the store checker.
//               memwrite  - store strobe, one cycle per committed store
//               dataadr   - 32-bit store byte address
//               writedata - 32-bit store data
//               master: the processor side (drives the store)
//               slave : the checker side (observes the store)
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_store_checker_if;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;

    modport master (
        output memwrite,
        output dataadr,
        output writedata
    );

    modport slave (
        input  memwrite,
        input  dataadr,
        input  writedata
    );
endinterface
`default_nettype wire

// File: rtl/mips_store_checker.sv
`default_nettype none
// ============================================================================
// Module      : mips_store_checker
// Description : Self-check stage that watches the MIPS data-memory write port,
//               classifies every store and latches a sticky verdict
//               (RUN / PASS / FAIL / TIMEOUT). Keeps store and cycle counters
//               and a 4-deep history of the most recent stores.
// Ports       : clk         - rising-edge clock shared with the core
//               reset       - asynchronous reset, active-low
//               bus         - store port (memwrite, dataadr, writedata)
//               done        - high in any terminal state
//               pass        - high only in PASS
//               status      - 00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT
//               write_count - stores seen while running (saturating)
//               cycle_count - running cycles elapsed (saturating)
//               fail_addr   - address of the store that caused FAIL
//               fail_data   - data of the store that caused FAIL
//               hist_sel    - history index, 0 = newest store
//               hist_addr   - address of the selected history entry
//               hist_data   - data of the selected history entry
// Revision    : 1.0 - initial release
// ============================================================================
module mips_store_checker #(
    parameter logic [31:0] PASS_ADDR      = 32'd84,
    parameter logic [31:0] PASS_DATA      = 32'd7,
    parameter logic [31:0] ALLOW_ADDR     = 32'd80,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          CNT_W          = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    mips_store_checker_if.slave   bus,
    output logic                  done,
    output logic                  pass,
    output logic [1:0]            status,
    output logic [CNT_W-1:0]      write_count,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [31:0]           fail_addr,
    output logic [31:0]           fail_data,
    input  wire logic [1:0]       hist_sel,
    output logic [31:0]           hist_addr,
    output logic [31:0]           hist_data
);

    // The state encoding is the status code itself, so status is a plain
    // copy of the state register.
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_PASS    = 2'b01,
        ST_FAIL    = 2'b10,
        ST_TIMEOUT = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_MAX     = {CNT_W{1'b1}};
    // Value of cycle_count on the edge that completes the last allowed cycle.
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q,       state_d;
    logic [CNT_W-1:0]  write_count_q, write_count_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [31:0]       fail_addr_q,   fail_addr_d;
    logic [31:0]       fail_data_q,   fail_data_d;
    logic [31:0]       hist_addr_q [4];
    logic [31:0]       hist_addr_d [4];
    logic [31:0]       hist_data_q [4];
    logic [31:0]       hist_data_d [4];
    logic [1:0]        wr_ptr_q,      wr_ptr_d;

    logic              pass_hit;
    logic              fail_hit;
    logic              timeout_hit;
    logic [1:0]        rd_idx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == C_CNT_MAX) ? v : v + C_CNT_ONE;
    endfunction

    // ------------------------------------------------------------------
    // Store classification. Pass is checked first, so a store to
    // PASS_ADDR with the wrong data falls through to the fail check
    // (PASS_ADDR is never the allowed address).
    // ------------------------------------------------------------------
    always_comb begin
        pass_hit    = 1'b0;
        fail_hit    = 1'b0;
        timeout_hit = 1'b0;
        if (bus.memwrite) begin
            if ((bus.dataadr == PASS_ADDR) && (bus.writedata == PASS_DATA)) begin
                pass_hit = 1'b1;
            end else if (bus.dataadr != ALLOW_ADDR) begin
                fail_hit = 1'b1;
            end
        end
        // Only matters when no store verdict fires on the same edge.
        if (cycle_count_q == C_TIMEOUT_LAST) begin
            timeout_hit = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath updates; everything freezes once the state
    // leaves RUN.
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        write_count_d = write_count_q;
        cycle_count_d = cycle_count_q;
        fail_addr_d   = fail_addr_q;
        fail_data_d   = fail_data_q;
        hist_addr_d   = hist_addr_q;
        hist_data_d   = hist_data_q;
        wr_ptr_d      = wr_ptr_q;

        if (state_q == ST_RUN) begin
            cycle_count_d = sat_inc(cycle_count_q);

            if (bus.memwrite) begin
                write_count_d         = sat_inc(write_count_q);
                hist_addr_d[wr_ptr_q] = bus.dataadr;
                hist_data_d[wr_ptr_q] = bus.writedata;
                wr_ptr_d              = wr_ptr_q + 2'd1;
            end

            if (pass_hit) begin
                state_d = ST_PASS;
            end else if (fail_hit) begin
                state_d     = ST_FAIL;
                fail_addr_d = bus.dataadr;
                fail_data_d = bus.writedata;
            end else if (timeout_hit) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            write_count_q <= '0;
            cycle_count_q <= '0;
            fail_addr_q   <= '0;
            fail_data_q   <= '0;
            hist_addr_q   <= '{default: '0};
            hist_data_q   <= '{default: '0};
            wr_ptr_q      <= 2'd0;
        end else begin
            state_q       <= state_d;
            write_count_q <= write_count_d;
            cycle_count_q <= cycle_count_d;
            fail_addr_q   <= fail_addr_d;
            fail_data_q   <= fail_data_d;
            hist_addr_q   <= hist_addr_d;
            hist_data_q   <= hist_data_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // History read: wr_ptr points at the next free slot, so the newest
    // entry sits one behind it. The 2-bit arithmetic provides the mod-4
    // wrap. Slots never written still hold their reset value of 0.
    // ------------------------------------------------------------------
    always_comb begin
        rd_idx    = wr_ptr_q - 2'd1 - hist_sel;
        hist_addr = hist_addr_q[rd_idx];
        hist_data = hist_data_q[rd_idx];
    end

    assign status      = state_q;
    assign done        = (state_q != ST_RUN);
    assign pass        = (state_q == ST_PASS);
    assign write_count = write_count_q;
    assign cycle_count = cycle_count_q;
    assign fail_addr   = fail_addr_q;
    assign fail_data   = fail_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_store_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_store_checker
// Description : Self-checking bench for mips_store_checker. Instance A uses
//               the default parameters and is tracked by a behavioural
//               model; instance B uses TIMEOUT_CYCLES=20 for the timeout
//               scenarios. Both see the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_store_checker;

    localparam int TO_A = 1000;
    localparam int TO_B = 20;

    logic        clk;
    logic        reset;
    logic [1:0]  hist_sel;

    mips_store_checker_if bus_a ();
    mips_store_checker_if bus_b ();

    logic        a_done, a_pass, b_done, b_pass;
    logic [1:0]  a_status, b_status;
    logic [15:0] a_wc, a_cc, b_wc, b_cc;
    logic [31:0] a_fa, a_fd, a_ha, a_hd, b_fa, b_fd, b_ha, b_hd;

    mips_store_checker #(.TIMEOUT_CYCLES(TO_A)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave),
        .done(a_done), .pass(a_pass), .status(a_status),
        .write_count(a_wc), .cycle_count(a_cc),
        .fail_addr(a_fa), .fail_data(a_fd),
        .hist_sel(hist_sel), .hist_addr(a_ha), .hist_data(a_hd)
    );

    mips_store_checker #(.TIMEOUT_CYCLES(TO_B)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave),
        .done(b_done), .pass(b_pass), .status(b_status),
        .write_count(b_wc), .cycle_count(b_cc),
        .fail_addr(b_fa), .fail_data(b_fd),
        .hist_sel(hist_sel), .hist_addr(b_ha), .hist_data(b_hd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- behavioural model of instance A ----------------
    logic [1:0]  m_status;
    int          m_wc, m_cc;
    logic [31:0] m_fa, m_fd;
    logic [63:0] m_hist[$];   // newest first, {addr,data}

    task automatic m_reset();
        m_status = 2'b00;
        m_wc = 0; m_cc = 0; m_fa = 0; m_fd = 0;
        m_hist.delete();
    endtask

    task automatic m_step(input logic mw, input logic [31:0] a, input logic [31:0] d);
        int cycles_before;
        if (m_status == 2'b00) begin
            cycles_before = m_cc;
            m_cc = m_cc + 1;
            if (mw) begin
                m_wc = m_wc + 1;
                m_hist.push_front({a, d});
                if (m_hist.size() > 4) void'(m_hist.pop_back());
                if (a == 32'd84 && d == 32'd7) m_status = 2'b01;
                else if (a != 32'd80) begin
                    m_status = 2'b10; m_fa = a; m_fd = d;
                end
            end
            if (m_status == 2'b00 && cycles_before + 1 == TO_A) m_status = 2'b11;
        end
    endtask

    function automatic logic [63:0] m_hist_at(input int sel);
        return (sel < m_hist.size()) ? m_hist[sel] : 64'd0;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    // Drive one cycle of stimulus, clock it, and sample 1ns after the edge.
    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d);
        bus_a.memwrite = mw; bus_a.dataadr = a; bus_a.writedata = d;
        bus_b.memwrite = mw; bus_b.dataadr = a; bus_b.writedata = d;
        @(posedge clk);
        #1;
        m_step(mw, a, d);
        bus_a.memwrite = 1'b0; bus_b.memwrite = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        bus_a.memwrite = 1'b0; bus_a.dataadr = '0; bus_a.writedata = '0;
        bus_b.memwrite = 1'b0; bus_b.dataadr = '0; bus_b.writedata = '0;
        hist_sel = 2'd0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({a_status, a_done, a_pass} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: got %b required 0000", {a_status, a_done, a_pass}); end
        checks++; if ({a_wc, a_cc} !== 32'd0) begin
            failures++; $display("FAIL reset_counters: got %h required 0", {a_wc, a_cc}); end
        checks++; if ({a_fa, a_fd} !== 64'd0) begin
            failures++; $display("FAIL reset_fail_capture: got %h required 0", {a_fa, a_fd}); end
        for (int s = 0; s < 4; s++) begin
            hist_sel = 2'(s); #1;
            checks++; if ({a_ha, a_hd} !== 64'd0) begin
                failures++; $display("FAIL reset_hist[%0d]: got %h required 0", s, {a_ha, a_hd}); end
        end
        apply_reset();
    endtask

    task automatic test_pass_sequence();
        apply_reset();
        step(1'b1, 32'd80, 32'd3);
        checks++; if (a_status !== 2'b00 || a_wc !== 16'd1) begin
            failures++; $display("FAIL allowed_store: got status=%b wc=%0d required 00/1", a_status, a_wc); end
        step(1'b1, 32'd80, 32'd5);
        step(1'b1, 32'd84, 32'd7);
        checks++; if ({a_status, a_pass, a_done} !== 4'b0111 || a_wc !== 16'd3) begin
            failures++; $display("FAIL pass_verdict: got status=%b pass=%b done=%b wc=%0d required 01/1/1/3",
                                 a_status, a_pass, a_done, a_wc); end
        step(1'b1, 32'd0, 32'd0);
        checks++; if (a_status !== 2'b01 || a_wc !== 16'd3 || a_cc !== 16'(m_cc) || {a_fa, a_fd} !== 64'd0) begin
            failures++; $display("FAIL pass_sticky: got status=%b wc=%0d cc=%0d fa=%0h required 01/3/%0d/0",
                                 a_status, a_wc, a_cc, a_fa, m_cc); end
        hist_sel = 2'd0; #1;
        checks++; if ({a_ha, a_hd} !== {32'd84, 32'd7}) begin
            failures++; $display("FAIL pass_hist_frozen: got %0d,%0d required 84,7", a_ha, a_hd); end
    endtask

    task automatic test_fail_captures();
        apply_reset();
        step(1'b1, 32'd84, 32'd6);
        checks++; if ({a_status, a_pass, a_done} !== 4'b1001 || a_fa !== 32'd84 || a_fd !== 32'd6) begin
            failures++; $display("FAIL fail_wrong_data: got status=%b pass=%b fa=%0d fd=%0d required 10/0/84/6",
                                 a_status, a_pass, a_fa, a_fd); end
        apply_reset();
        step(1'b0, 32'd100, 32'd9);   // no strobe: address ignored
        step(1'b1, 32'd100, 32'd7);
        checks++; if (a_status !== 2'b10 || a_fa !== 32'd100 || a_fd !== 32'd7 || a_wc !== 16'd1) begin
            failures++; $display("FAIL fail_bad_addr: got status=%b fa=%0d fd=%0d wc=%0d required 10/100/7/1",
                                 a_status, a_fa, a_fd, a_wc); end
        step(1'b1, 32'd84, 32'd7);
        checks++; if (a_status !== 2'b10 || a_fa !== 32'd100) begin
            failures++; $display("FAIL fail_sticky: got status=%b fa=%0d required 10/100", a_status, a_fa); end
    endtask

    task automatic test_timeout();
        int bad;
        apply_reset();
        bad = 0;
        for (int i = 1; i < TO_B; i++) begin
            step(1'b0, 32'd0, 32'd0);
            if (b_status !== 2'b00 || b_cc !== 16'(i)) bad++;
        end
        checks++; if (bad != 0) begin
            failures++; $display("FAIL timeout_early: got %0d bad cycles required 0", bad); end
        step(1'b0, 32'd0, 32'd0);
        checks++; if (b_status !== 2'b11 || b_cc !== 16'd20 || b_done !== 1'b1 || b_pass !== 1'b0) begin
            failures++; $display("FAIL timeout_fire: got status=%b cc=%0d done=%b required 11/20/1",
                                 b_status, b_cc, b_done); end
        step(1'b0, 32'd0, 32'd0);
        checks++; if (b_status !== 2'b11 || b_cc !== 16'd20) begin
            failures++; $display("FAIL timeout_frozen: got status=%b cc=%0d required 11/20", b_status, b_cc); end

        apply_reset();
        repeat (TO_B - 1) step(1'b0, 32'd0, 32'd0);
        step(1'b1, 32'd84, 32'd7);
        checks++; if (b_status !== 2'b01 || b_cc !== 16'd20 || b_wc !== 16'd1) begin
            failures++; $display("FAIL store_beats_timeout: got status=%b cc=%0d wc=%0d required 01/20/1",
                                 b_status, b_cc, b_wc); end
    endtask

    task automatic test_history();
        apply_reset();
        for (int i = 1; i <= 6; i++) step(1'b1, 32'd80, 32'(i));
        checks++; if (a_wc !== 16'd6 || a_status !== 2'b00) begin
            failures++; $display("FAIL hist_wc: got wc=%0d status=%b required 6/00", a_wc, a_status); end
        for (int s = 0; s < 4; s++) begin
            hist_sel = 2'(s); #1;
            checks++; if (a_ha !== 32'd80 || a_hd !== 32'(6 - s)) begin
                failures++; $display("FAIL hist_read[%0d]: got %0d,%0d required 80,%0d", s, a_ha, a_hd, 6 - s); end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 32'd80, 32'(i + 10));
        #3 reset = 1'b0;
        m_reset();
        #1;
        hist_sel = 2'd0;
        #0.5;
        checks++; if ({a_status, a_done, a_pass} !== 4'd0 || a_wc !== 16'd0 || a_cc !== 16'd0 || {a_ha, a_hd} !== 64'd0) begin
            failures++; $display("FAIL async_reset: got status=%b wc=%0d cc=%0d hist=%h required all 0",
                                 a_status, a_wc, a_cc, {a_ha, a_hd}); end
        #1 reset = 1'b1;
        step(1'b1, 32'd84, 32'd7);
        checks++; if (a_status !== 2'b01 || a_wc !== 16'd1 || a_cc !== 16'd1) begin
            failures++; $display("FAIL after_async_reset: got status=%b wc=%0d cc=%0d required 01/1/1",
                                 a_status, a_wc, a_cc); end
    endtask

    task automatic test_random();
        logic        mw;
        logic [31:0] a, d;
        logic [63:0] exp_h;
        int          r;
        for (int run = 0; run < 12; run++) begin
            apply_reset();
            for (int c = 0; c < 24; c++) begin
                mw = ($urandom_range(0, 3) != 0);
                r  = $urandom_range(0, 19);
                a  = (r < 15) ? 32'd80 : (r < 18) ? 32'd84 : $urandom;
                d  = ($urandom_range(0, 1) != 0) ? 32'd7 : 32'($urandom_range(0, 15));
                step(mw, a, d);
                hist_sel = 2'($urandom_range(0, 3));
                #1;
                exp_h = m_hist_at(int'(hist_sel));
                checks++; if (a_status !== m_status || a_done !== (m_status != 2'b00) || a_pass !== (m_status == 2'b01)) begin
                    failures++; $display("FAIL rand_status: got %b/%b/%b required %b", a_status, a_done, a_pass, m_status); end
                checks++; if (a_wc !== 16'(m_wc) || a_cc !== 16'(m_cc)) begin
                    failures++; $display("FAIL rand_counts: got wc=%0d cc=%0d required %0d/%0d", a_wc, a_cc, m_wc, m_cc); end
                checks++; if (a_fa !== m_fa || a_fd !== m_fd) begin
                    failures++; $display("FAIL rand_fail_capture: got %h/%h required %h/%h", a_fa, a_fd, m_fa, m_fd); end
                checks++; if ({a_ha, a_hd} !== exp_h) begin
                    failures++; $display("FAIL rand_hist[%0d]: got %h required %h", hist_sel, {a_ha, a_hd}, exp_h); end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        hist_sel = 2'd0;
        bus_a.memwrite = 1'b0; bus_a.dataadr = '0; bus_a.writedata = '0;
        bus_b.memwrite = 1'b0; bus_b.dataadr = '0; bus_b.writedata = '0;
        test_reset();
        test_pass_sequence();
        test_fail_captures();
        test_timeout();
        test_history();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
